hub_slot_sched: RTL and testbench

Hub time-slot scheduler for the Propeller hub bus. Generates the ena_bus strobe and one-hot bus_sel that grant each cog its hub window in fixed round-robin order. Can insert one extra "external" slot per rotation for a non-cog requester (debug/DMA port) via a req/gnt handshake. Sits between the clock/reset logic and the hub and cog array, in place of free-running slot logic.

---
 rtl/hub_slot_sched.sv | 174 +++++++++++++++++
 tb/tb_hub_slot_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hub_slot_sched.sv
// Hub time-slot scheduler: round-robin cog windows plus one optional external slot per rotation.
// Optional build macro SKIP_IDLE_EN: skip cogs whose cog_ena bit is clear.
module hub_slot_sched #(
    parameter int NUMCOGS  = 8,
    parameter int SLOT_CYC = 2
) (
    input  logic       clk_cog,
    input  logic       inp_res,
    input  logic       run,
    input  logic [7:0] cog_ena,
    input  logic       ext_req,
    output logic       ext_gnt,
    output logic       ena_bus,
    output logic [7:0] bus_sel,
    output logic [2:0] slot_idx,
    output logic [7:0] rot_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COG,
        S_EXT
    } state_t;

    localparam logic [3:0] PH_LAST  = 4'(SLOT_CYC - 1);
    localparam logic [2:0] COG_LAST = 3'(NUMCOGS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nxt;
    logic [7:0] r_rot;
    logic [7:0] w_rot_nxt;
    logic [3:0] r_ph;
    logic [3:0] w_ph_nxt;
    logic       r_ena_bus;

    assign w_ph_nxt = (r_ph == PH_LAST) ? 4'd0 : r_ph + 4'd1;

`ifdef SKIP_IDLE_EN
    logic [7:0] w_ena_m;
    logic       w_lo_hit;
    logic [2:0] w_lo_idx;
    logic       w_up_hit;
    logic [2:0] w_up_idx;

    assign w_ena_m = cog_ena & 8'((9'd1 << NUMCOGS) - 9'd1);

    // Lowest enabled cog overall, and lowest enabled cog above the current owner.
    always_comb begin
        w_lo_hit = 1'b0;
        w_lo_idx = '0;
        w_up_hit = 1'b0;
        w_up_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (w_ena_m[i] && !w_lo_hit) begin
                w_lo_hit = 1'b1;
                w_lo_idx = 3'(i);
            end
            if (w_ena_m[i] && !w_up_hit && (3'(i) > r_idx)) begin
                w_up_hit = 1'b1;
                w_up_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rot_nxt   = r_rot;
        case (r_state)
            S_IDLE: begin
                if (w_lo_hit) begin
                    w_state_nxt = S_COG;
                    w_idx_nxt   = w_lo_idx;
                end else begin
                    // An empty slot still counts as a rotation boundary.
                    w_rot_nxt   = r_rot + 8'd1;
                    w_state_nxt = ext_req ? S_EXT : S_IDLE;
                    w_idx_nxt   = '0;
                end
            end
            S_COG: begin
                if (w_up_hit) begin
                    w_idx_nxt = w_up_idx;
                end else begin
                    w_rot_nxt = r_rot + 8'd1;
                    if (ext_req) begin
                        w_state_nxt = S_EXT;
                        w_idx_nxt   = '0;
                    end else if (w_lo_hit) begin
                        w_idx_nxt = w_lo_idx;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                    end
                end
            end
            S_EXT: begin
                w_state_nxt = w_lo_hit ? S_COG : S_IDLE;
                w_idx_nxt   = w_lo_hit ? w_lo_idx : 3'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end
`else
    logic w_unused_ena;
    assign w_unused_ena = ^cog_ena;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rot_nxt   = r_rot;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_COG;
                w_idx_nxt   = '0;
            end
            S_COG: begin
                if (r_idx == COG_LAST) begin
                    w_rot_nxt   = r_rot + 8'd1;
                    w_state_nxt = ext_req ? S_EXT : S_COG;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + 3'd1;
                end
            end
            S_EXT: begin
                w_state_nxt = S_COG;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end
`endif

    // Advance fires on the edge where ena_bus is already high, i.e. ph is at its last value.
    always_ff @(posedge clk_cog or posedge inp_res) begin
        if (inp_res) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_rot     <= '0;
            r_ph      <= '0;
            r_ena_bus <= 1'b0;
        end else if (!run) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_rot     <= '0;
            r_ph      <= '0;
            r_ena_bus <= 1'b0;
        end else begin
            r_ph      <= w_ph_nxt;
            r_ena_bus <= (w_ph_nxt == PH_LAST);
            if (r_ena_bus) begin
                r_state <= w_state_nxt;
                r_idx   <= w_idx_nxt;
                r_rot   <= w_rot_nxt;
            end
        end
    end

    assign ena_bus  = r_ena_bus;
    assign ext_gnt  = (r_state == S_EXT);
    assign bus_sel  = (r_state == S_COG) ? (8'd1 << r_idx) : 8'd0;
    assign slot_idx = r_idx;
    assign rot_cnt  = r_rot;

endmodule

// File: tb/tb_hub_slot_sched.sv
// Directed bench for hub_slot_sched: 8-cog/2-clock instance and a 4-cog/3-clock instance.
module tb_hub_slot_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_b;
    logic       run;
    logic [7:0] cog_ena;
    logic       ext_req;
    logic       ext_gnt, ena_bus;
    logic [7:0] bus_sel, rot_cnt;
    logic [2:0] slot_idx;
    logic       ext_gnt_b, ena_bus_b;
    logic [7:0] bus_sel_b, rot_cnt_b;
    logic [2:0] slot_idx_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hub_slot_sched #(.NUMCOGS(8), .SLOT_CYC(2)) u_dut (
        .clk_cog (clk),
        .inp_res (rst),
        .run     (run),
        .cog_ena (cog_ena),
        .ext_req (ext_req),
        .ext_gnt (ext_gnt),
        .ena_bus (ena_bus),
        .bus_sel (bus_sel),
        .slot_idx(slot_idx),
        .rot_cnt (rot_cnt)
    );

    hub_slot_sched #(.NUMCOGS(4), .SLOT_CYC(3)) u_dut_b (
        .clk_cog (clk),
        .inp_res (rst_b),
        .run     (1'b1),
        .cog_ena (8'hFF),
        .ext_req (1'b0),
        .ext_gnt (ext_gnt_b),
        .ena_bus (ena_bus_b),
        .bus_sel (bus_sel_b),
        .slot_idx(slot_idx_b),
        .rot_cnt (rot_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One 2-clock slot of the main instance: ena_bus low on the first clock, high on the last.
    task automatic any_slot(input logic [7:0] sel, input logic [2:0] idx, input logic gnt,
                            input logic [7:0] rot, input bit drop);
        cyc();
        chk("slot_ena0", {31'd0, ena_bus}, 32'd0);
        chk("slot_sel", {24'd0, bus_sel}, {24'd0, sel});
        chk("slot_idx", {29'd0, slot_idx}, {29'd0, idx});
        chk("slot_gnt", {31'd0, ext_gnt}, {31'd0, gnt});
        chk("slot_rot", {24'd0, rot_cnt}, {24'd0, rot});
        if (drop) ext_req = 1'b0;
        cyc();
        chk("slot_ena1", {31'd0, ena_bus}, 32'd1);
        chk("slot_sel_hold", {24'd0, bus_sel}, {24'd0, sel});
        chk("slot_gnt_hold", {31'd0, ext_gnt}, {31'd0, gnt});
    endtask

    task automatic cogs(input int first, input int last, input logic [7:0] rot);
        for (int k = first; k <= last; k++)
            any_slot(8'(1 << k), 3'(k), 1'b0, rot, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1; run = 1'b1; cog_ena = 8'hFF; ext_req = 1'b0;
        #2;
        chk("rst_sel", {24'd0, bus_sel}, 32'd0);
        chk("rst_ena", {31'd0, ena_bus}, 32'd0);
        chk("rst_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("rst_rot", {24'd0, rot_cnt}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Plain rotation from reset release
        cyc();
        chk("edge1_ena", {31'd0, ena_bus}, 32'd1);
        chk("edge1_sel", {24'd0, bus_sel}, 32'd0);
        cogs(0, 7, 8'd0);
        cogs(0, 2, 8'd1);

        // ext_req held: one EXT per rotation, dropped during the second EXT
        ext_req = 1'b1;
        cogs(3, 7, 8'd1);
        any_slot(8'h00, 3'd0, 1'b1, 8'd2, 1'b0);
        cogs(0, 7, 8'd2);
        any_slot(8'h00, 3'd0, 1'b1, 8'd3, 1'b1);
        cogs(0, 7, 8'd3);

        // Request pulsed and withdrawn before the boundary
        cogs(0, 4, 8'd4);
        ext_req = 1'b1;
        cogs(5, 5, 8'd4);
        ext_req = 1'b0;
        cogs(6, 7, 8'd4);
        cogs(0, 0, 8'd5);

        // run=0 for one edge during EXT
        ext_req = 1'b1;
        cogs(1, 7, 8'd5);
        cyc();
        chk("ext_run_gnt", {31'd0, ext_gnt}, 32'd1);
        chk("ext_run_sel", {24'd0, bus_sel}, 32'd0);
        run = 1'b0;
        cyc();
        chk("run0_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("run0_sel", {24'd0, bus_sel}, 32'd0);
        chk("run0_rot", {24'd0, rot_cnt}, 32'd0);
        chk("run0_ena", {31'd0, ena_bus}, 32'd0);
        run = 1'b1; ext_req = 1'b0;
        cyc();
        chk("rerun_ena", {31'd0, ena_bus}, 32'd1);
        chk("rerun_sel", {24'd0, bus_sel}, 32'd0);
        cogs(0, 3, 8'd0);
        ext_req = 1'b1;
        cogs(4, 7, 8'd0);

        // Async reset during EXT drops the grant immediately
        cyc();
        chk("ext2_gnt", {31'd0, ext_gnt}, 32'd1);
        chk("ext2_rot", {24'd0, rot_cnt}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("arst_rot", {24'd0, rot_cnt}, 32'd0);
        chk("arst_sel", {24'd0, bus_sel}, 32'd0);
        ext_req = 1'b0;
        @(negedge clk); rst = 1'b0;

        // 4 cogs, 3 clocks per slot
        @(negedge clk); rst_b = 1'b0;
        cyc();
        chk("b_e1_ena", {31'd0, ena_bus_b}, 32'd0);
        cyc();
        chk("b_e2_ena", {31'd0, ena_bus_b}, 32'd1);
        chk("b_e2_sel", {24'd0, bus_sel_b}, 32'd0);
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 3; c++) begin
                cyc();
                chk("b_ena", {31'd0, ena_bus_b}, (c == 2) ? 32'd1 : 32'd0);
                chk("b_sel", {24'd0, bus_sel_b}, 32'(1 << (s % 4)));
            end
            chk("b_idx", {29'd0, slot_idx_b}, 32'(s % 4));
            chk("b_rot", {24'd0, rot_cnt_b}, 32'(s / 4));
            chk("b_gnt", {31'd0, ext_gnt_b}, 32'd0);
        end

`ifdef SKIP_IDLE_EN
        // Skip disabled cogs; empty mask yields IDLE slots that can grant EXT
        @(negedge clk);
        rst = 1'b1; cog_ena = 8'h05; ext_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        cyc();
        chk("sk_e1_ena", {31'd0, ena_bus}, 32'd1);
        any_slot(8'h01, 3'd0, 1'b0, 8'd0, 1'b0);
        any_slot(8'h04, 3'd2, 1'b0, 8'd0, 1'b0);
        any_slot(8'h01, 3'd0, 1'b0, 8'd1, 1'b0);
        any_slot(8'h04, 3'd2, 1'b0, 8'd1, 1'b0);
        any_slot(8'h01, 3'd0, 1'b0, 8'd2, 1'b0);
        any_slot(8'h04, 3'd2, 1'b0, 8'd2, 1'b0);
        cog_ena = 8'h00;
        any_slot(8'h00, 3'd0, 1'b0, 8'd3, 1'b0);
        ext_req = 1'b1;
        any_slot(8'h00, 3'd0, 1'b1, 8'd4, 1'b0);
        any_slot(8'h00, 3'd0, 1'b0, 8'd4, 1'b0);
        ext_req = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
